execute_operand_packer: RTL and testbench

EXECUTE_OPERAND_PACKER -- requirements
Module: execute_operand_packer

---
 rtl/execute_operand_packer.sv | 166 ++++++++++++++++
 tb/tb_execute_operand_packer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_operand_packer.sv
`default_nettype none
// ============================================================================
// Module      : execute_operand_packer
// Description : Reads words from a latency-1 execute data queue, packs SCALER
//               consecutive words into one operand vector and presents each
//               vector on a valid/ready output register. It runs one job of
//               cfg_len vectors per start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_operand_packer #(
  parameter int WIDTH  = 32,
  parameter int SCALER = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [15:0]               cfg_len,
  output logic                      busy,
  output logic                      done,
  input  logic                      fifo_empty,
  output logic                      fifo_rd_en,
  input  logic [WIDTH-1:0]          fifo_dout,
  output logic [WIDTH*SCALER-1:0]   op_data,
  output logic                      op_valid,
  input  logic                      op_ready,
  output logic                      op_last
);

  // One spare bit above len*SCALER so the word/vector counters cannot wrap.
  localparam int CW = 17 + $clog2(SCALER);
  // Lane counter must hold 0..SCALER inclusive (SCALER means "pack full").
  localparam int LW = $clog2(SCALER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [15:0]               len_q, len_d;
  logic [CW-1:0]             issued_q, issued_d;
  logic [CW-1:0]             moved_q, moved_d;
  logic                      inflight_q, inflight_d;
  logic [LW-1:0]             lane_cnt_q, lane_cnt_d;
  logic [WIDTH*SCALER-1:0]   pack_q, pack_d;
  logic [WIDTH*SCALER-1:0]   op_data_q, op_data_d;
  logic                      op_valid_q, op_valid_d;
  logic                      op_last_q, op_last_d;

  logic [CW-1:0]             total_words;
  logic [31:0]               occupancy;
  logic                      rd_en;
  logic                      handshake;

  // Read strobe: only in RUN, only while the queue has data, the local
  // storage (pack + in-flight + output register) has room for another word,
  // and the job still needs more words.
  always_comb begin
    total_words = CW'(len_q) * CW'(SCALER);
    occupancy   = 32'(lane_cnt_q) + 32'(inflight_q)
                + (op_valid_q ? 32'(SCALER) : 32'd0);
    rd_en       = (state_q == RUN) && !fifo_empty
                && (occupancy < 32'(2 * SCALER))
                && (issued_q < total_words);
    handshake   = op_valid_q && op_ready;
  end

  // Next-state: word capture into the pack, pack-to-output transfer, FSM.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = rd_en ? issued_q + CW'(1) : issued_q;
    moved_d    = moved_q;
    inflight_d = rd_en;
    lane_cnt_d = lane_cnt_q;
    pack_d     = pack_q;
    op_data_d  = op_data_q;
    op_valid_d = op_valid_q;
    op_last_d  = op_last_q;

    // The word requested last cycle lands in the next free lane.
    if (inflight_q && (lane_cnt_q != LW'(SCALER))) begin
      for (int k = 0; k < SCALER; k++) begin
        if (lane_cnt_q == LW'(k)) begin
          pack_d[k*WIDTH +: WIDTH] = fifo_dout;
        end
      end
      lane_cnt_d = lane_cnt_q + LW'(1);
    end

    if (handshake) begin
      op_valid_d = 1'b0;
      op_last_d  = 1'b0;
    end

    // A full pack (including one completed this very edge) moves out as soon
    // as the output register is free or being drained.
    if ((lane_cnt_d == LW'(SCALER)) && (!op_valid_q || handshake)) begin
      op_data_d  = pack_d;
      op_valid_d = 1'b1;
      op_last_d  = (moved_q == (CW'(len_q) - CW'(1)));
      moved_d    = moved_q + CW'(1);
      lane_cnt_d = '0;
      pack_d     = '0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = cfg_len;
          issued_d = '0;
          moved_d  = '0;
          state_d  = (cfg_len == 16'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (handshake && op_last_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      moved_q    <= '0;
      inflight_q <= 1'b0;
      lane_cnt_q <= '0;
      pack_q     <= '0;
      op_data_q  <= '0;
      op_valid_q <= 1'b0;
      op_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      moved_q    <= moved_d;
      inflight_q <= inflight_d;
      lane_cnt_q <= lane_cnt_d;
      pack_q     <= pack_d;
      op_data_q  <= op_data_d;
      op_valid_q <= op_valid_d;
      op_last_q  <= op_last_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign fifo_rd_en = rd_en;
  assign op_data    = op_data_q;
  assign op_valid   = op_valid_q;
  assign op_last    = op_last_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_operand_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_operand_packer
// Description : Self-checking bench for execute_operand_packer (WIDTH=32,
//               SCALER=2) with a latency-1 queue model and a vector scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_operand_packer;

  localparam int W = 32;
  localparam int S = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [15:0]      cfg_len;
  logic             busy;
  logic             done;
  logic             fifo_empty = 1'b1;
  logic             fifo_rd_en;
  logic [W-1:0]     fifo_dout = '0;
  logic [W*S-1:0]   op_data;
  logic             op_valid;
  logic             op_ready;
  logic             op_last;

  execute_operand_packer #(.WIDTH(W), .SCALER(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_len    (cfg_len),
    .busy       (busy),
    .done       (done),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .op_data    (op_data),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_last    (op_last)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue model and scoreboard state
  logic [W-1:0]   fq[$];
  logic [W*S-1:0] exp_d[$];
  bit             exp_l[$];
  bit             toggle_en = 1'b0;
  bit             phase     = 1'b0;
  int             cyc = 0;
  int             rd_count = 0;
  int             hs_count = 0;
  int             done_count = 0;
  int             first_valid_cyc = -1;
  int             last_hs_cyc = 0;
  int             done_cyc = 0;
  int             start_cyc = 0;
  bit             prev_stall = 1'b0;
  logic [W*S-1:0] prev_data = '0;
  logic           prev_last = 1'b0;

  // Queue responder: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    cyc++;
    if (fifo_rd_en) begin
      check("rd_legal", fifo_empty || !busy, 1'b0);
      rd_count++;
      if (fq.size() != 0) fifo_dout <= fq.pop_front();
      else                fifo_dout <= '0;
    end
  end

  // Empty flag updated mid-cycle, optionally toggled every other cycle.
  always @(negedge clk) begin
    phase      = ~phase;
    fifo_empty = (fq.size() == 0) || (toggle_en && phase);
  end

  // Output monitor: hold stability, scoreboard compare, timing capture.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_data", op_data, prev_data);
        check("hold_last", op_last, prev_last);
      end
      prev_stall = op_valid && !op_ready;
      prev_data  = op_data;
      prev_last  = op_last;
      if (op_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (op_valid && op_ready) begin
        check("vec_expected", exp_d.size() != 0, 1'b1);
        if (exp_d.size() != 0) begin
          check("op_data", op_data, exp_d.pop_front());
          check("op_last", op_last, exp_l.pop_front());
        end
        hs_count++;
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    rd_count        = 0;
    hs_count        = 0;
    first_valid_cyc = -1;
  endtask

  // Queue words base, base+step, ... and the vectors they should form.
  task automatic load(input int len, input logic [W-1:0] base, input logic [W-1:0] step);
    logic [W*S-1:0] v;
    for (int i = 0; i < len; i++) begin
      v = '0;
      for (int k = 0; k < S; k++) begin
        v[k*W +: W] = base + step * W'(i*S + k);
        fq.push_back(base + step * W'(i*S + k));
      end
      exp_d.push_back(v);
      exp_l.push_back(i == len - 1);
    end
  endtask

  task automatic start_job(input int len);
    cfg_len   = 16'(len);
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start   = 1'b0;
    cfg_len = 16'hFFFF;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_count;
    n  = 0;
    while (done_count == d0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, done_count > d0, 1'b1);
    tick();
  endtask

  task automatic check_idle_zero(input string pfx);
    check({pfx, "_busy"},  busy,       1'b0);
    check({pfx, "_done"},  done,       1'b0);
    check({pfx, "_valid"}, op_valid,   1'b0);
    check({pfx, "_last"},  op_last,    1'b0);
    check({pfx, "_data"},  op_data,    '0);
    check({pfx, "_rden"},  fifo_rd_en, 1'b0);
  endtask

  initial begin
    int n;
    int d0;
    rst_n    = 1'b0;
    start    = 1'b0;
    cfg_len  = '0;
    op_ready = 1'b1;
    repeat (3) tick();
    check_idle_zero("reset");
    rst_n = 1'b1;
    tick();

    // Basic two-vector job with latency checks
    clear_counts();
    load(2, 32'h11, 32'h11);
    start_job(2);
    wait_done("t1_done_timeout", 40);
    check("t1_first_lat", first_valid_cyc - start_cyc, 4);
    check("t1_last_lat",  last_hs_cyc - start_cyc, 6);
    check("t1_done_lat",  done_cyc - last_hs_cyc, 1);
    check("t1_reads",     rd_count, 4);
    check("t1_sb_empty",  exp_d.size(), 0);

    // Backpressure: consumer stalls for 12 cycles after first valid
    clear_counts();
    op_ready = 1'b0;
    load(4, 32'h100, 32'h1);
    start_job(4);
    n = 0;
    while (!op_valid && n < 40) begin
      tick();
      n++;
    end
    check("t2_valid_timeout", op_valid, 1'b1);
    repeat (12) tick();
    check("t2_reads_stalled", rd_count, 4);
    check("t2_no_hs",         hs_count, 0);
    op_ready = 1'b1;
    wait_done("t2_done_timeout", 60);
    check("t2_reads",    rd_count, 8);
    check("t2_vectors",  hs_count, 4);
    check("t2_sb_empty", exp_d.size(), 0);

    // Queue empty flag toggling every other cycle
    clear_counts();
    toggle_en = 1'b1;
    load(3, 32'h200, 32'h3);
    start_job(3);
    wait_done("t3_done_timeout", 80);
    toggle_en = 1'b0;
    check("t3_reads",    rd_count, 6);
    check("t3_vectors",  hs_count, 3);
    check("t3_sb_empty", exp_d.size(), 0);

    // Zero-length job
    clear_counts();
    start_job(0);
    check("t4_busy",  busy, 1'b1);
    check("t4_done",  done, 1'b1);
    tick();
    check("t4_busy_after", busy, 1'b0);
    check("t4_done_after", done, 1'b0);
    check("t4_reads", rd_count, 0);

    // Reset after first lane captured, then a fresh one-vector job
    clear_counts();
    load(2, 32'h1, 32'h1);
    start_job(2);
    tick();
    tick();
    rst_n = 1'b0;
    d0    = done_count;
    tick();
    check_idle_zero("t5_rst");
    rst_n = 1'b1;
    fq.delete();
    exp_d.delete();
    exp_l.delete();
    repeat (3) tick();
    check("t5_no_done", done_count, d0);
    check("t5_no_vec",  hs_count, 0);
    clear_counts();
    load(1, 32'hA, 32'h1);
    start_job(1);
    wait_done("t5_done_timeout", 40);
    check("t5_vectors",  hs_count, 1);
    check("t5_sb_empty", exp_d.size(), 0);

    // Start pulsed while running is ignored
    clear_counts();
    load(2, 32'h300, 32'h1);
    start_job(2);
    tick();
    cfg_len = 16'd5;
    start   = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t6_done_timeout", 40);
    repeat (4) tick();
    check("t6_vectors",  hs_count, 2);
    check("t6_reads",    rd_count, 4);
    check("t6_sb_empty", exp_d.size(), 0);
    check("t6_idle",     busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
